// File: rtl/sercmp_pkg.sv
// Shared types, cascade encoding and result decode for the bit-serial magnitude comparator.
package sercmp_pkg;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Cascade code to {lesser, greater, equal}; the unused code reads as equal.
  function automatic logic [2:0] cas_decode(input logic [1:0] cas);
    logic [2:0] res;
    case (cas)
      CMP_GT:  res = 3'b010;
      CMP_LT:  res = 3'b100;
      default: res = 3'b001;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cell.sv
// One-bit comparator cell: refines an EQ cascade state with the current bit pair, holds GT/LT.
module comparator_1bit_cell
  import sercmp_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic [1:0] cas_in,
  output logic [1:0] cas_out
);

  always_comb begin
    cas_out = cas_in;
    if (cas_in == CMP_EQ) begin
      if (ai && !bi)      cas_out = CMP_GT;
      else if (!ai && bi) cas_out = CMP_LT;
      else                cas_out = CMP_EQ;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/ready handshake and one-cycle done pulse.
// Optional build macro SERCMP_EARLY_EXIT_EN finishes as soon as the first differing bit is seen.
module serial_magnitude_comparator
  import sercmp_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             greater,
  output logic             equal
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [1:0]       cas, cas_nxt;
  logic [2:0]       res, res_nxt;
  logic             done_nxt;
  logic [1:0]       cell_out;
  logic             last_bit;

  comparator_1bit_cell u_cell (
    .ai      (a_sh[WIDTH-1]),
    .bi      (b_sh[WIDTH-1]),
    .cas_in  (cas),
    .cas_out (cell_out)
  );

`ifdef SERCMP_EARLY_EXIT_EN
  assign last_bit = (idx == '0) || (cell_out != CMP_EQ);
`else
  assign last_bit = (idx == '0);
`endif

  // Next-state, datapath and result update.
  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    idx_nxt   = idx;
    cas_nxt   = cas;
    res_nxt   = res;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          a_sh_nxt  = a;
          b_sh_nxt  = b;
          idx_nxt   = CNT_W'(WIDTH - 1);
          cas_nxt   = CMP_EQ;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cas_nxt  = cell_out;
        a_sh_nxt = a_sh << 1;
        b_sh_nxt = b_sh << 1;
        idx_nxt  = idx - CNT_W'(1);
        if (last_bit) begin
          res_nxt   = cas_decode(cell_out);
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      cas   <= CMP_EQ;
      res   <= '0;
      done  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_sh  <= a_sh_nxt;
      b_sh  <= b_sh_nxt;
      idx   <= idx_nxt;
      cas   <= cas_nxt;
      res   <= res_nxt;
      done  <= done_nxt;
      ready <= (state_nxt == S_IDLE);
      busy  <= (state_nxt == S_RUN);
    end
  end

  assign lesser  = res[2];
  assign greater = res[1];
  assign equal   = res[0];

endmodule
